// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: parametrised AXI4-Lite slave register bank.
//   The lower NUM_REGS-NUM_RO slots are read/write and are exported on ctrl_regs.
//   The top NUM_RO slots are read-only and reflect status_in.
//   Writing slot CMD_IDX with an OKAY response also raises cmd_pulse for one
//   cycle and presents the merged value on cmd_data.
// Ports:
//   S_AXI_*   : AXI4-Lite slave (AW/W/B write path, AR/R read path)
//   ctrl_regs : flattened RW registers, slot i at [i*DW +: DW]
//   status_in : flattened RO values, slot j is register index NUM_REGS-NUM_RO+j
//   busy_in   : engine busy; a write to CMD_IDX while busy answers SLVERR
//   cmd_pulse : one-cycle launch strobe
//   cmd_data  : value committed to CMD_IDX, valid with cmd_pulse
module axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 16,
  parameter int NUM_RO             = 2,
  parameter int CMD_IDX            = 7
) (
  input  logic                                            S_AXI_ACLK,
  input  logic                                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                   S_AXI_AWADDR,
  input  logic [2:0]                                      S_AXI_AWPROT,
  input  logic                                            S_AXI_AWVALID,
  output logic                                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                 S_AXI_WSTRB,
  input  logic                                            S_AXI_WVALID,
  output logic                                            S_AXI_WREADY,
  output logic [1:0]                                      S_AXI_BRESP,
  output logic                                            S_AXI_BVALID,
  input  logic                                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                   S_AXI_ARADDR,
  input  logic [2:0]                                      S_AXI_ARPROT,
  input  logic                                            S_AXI_ARVALID,
  output logic                                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                   S_AXI_RDATA,
  output logic [1:0]                                      S_AXI_RRESP,
  output logic                                            S_AXI_RVALID,
  input  logic                                            S_AXI_RREADY,
  output logic [(NUM_REGS-NUM_RO)*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]            status_in,
  input  logic                                            busy_in,
  output logic                                            cmd_pulse,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                   cmd_data
);

  localparam int          DW     = C_S_AXI_DATA_WIDTH;
  localparam int          IW     = C_S_AXI_ADDR_WIDTH - 2;
  localparam int          NB     = DW / 8;
  localparam int unsigned NUM_RW = NUM_REGS - NUM_RO;
  localparam int unsigned NREGS  = NUM_REGS;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic              ready_en;
  logic              aw_full;
  logic              w_full;
  logic [IW-1:0]     aw_idx;
  logic [DW-1:0]     w_data;
  logic [NB-1:0]     w_strb;
  logic [DW-1:0]     regs [NUM_RW];

  logic              ar_pend;
  logic [IW-1:0]     ar_idx;

  logic              commit;
  logic              wr_err;
  logic              wr_cmd;
  logic [DW-1:0]     wr_cur;
  logic [DW-1:0]     wr_merged;
  logic [DW-1:0]     rd_val;
  logic              rd_err;

  logic              unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Holds READY low while in reset; READY rises on the first edge after release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  assign S_AXI_AWREADY = ready_en && !aw_full && !S_AXI_BVALID;
  assign S_AXI_WREADY  = ready_en && !w_full  && !S_AXI_BVALID;
  // ar_pend covers the cycle between AR acceptance and RVALID rising.
  assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID && !ar_pend;

  // Write decode and byte merge on the buffered AW/W pair.
  always_comb begin
    commit = aw_full && w_full;
    wr_cmd = (32'(aw_idx) == 32'(CMD_IDX));
    wr_err = (32'(aw_idx) >= NUM_RW) || (wr_cmd && busy_in);
    wr_cur = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (aw_idx == IW'(i)) wr_cur = regs[i];
    end
    wr_merged = wr_cur;
    for (int unsigned b = 0; b < NB; b++) begin
      if (w_strb[b]) wr_merged[b*8 +: 8] = w_data[b*8 +: 8];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= OKAY;
      cmd_pulse    <= 1'b0;
      cmd_data     <= '0;
      for (int unsigned i = 0; i < NUM_RW; i++) regs[i] <= '0;
    end else begin
      cmd_pulse <= 1'b0;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      // Both buffers full implies both READYs are low, so a commit never
      // collides with a new handshake on the same edge.
      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_err ? SLVERR : OKAY;
        if (!wr_err) begin
          for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (aw_idx == IW'(i)) regs[i] <= wr_merged;
          end
          if (wr_cmd) begin
            cmd_pulse <= 1'b1;
            cmd_data  <= wr_merged;
          end
        end
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
        S_AXI_BRESP  <= OKAY;
      end
    end
  end

  // Read mux; regs here are the pre-commit values of the current edge.
  always_comb begin
    rd_val = '0;
    rd_err = (32'(ar_idx) >= NREGS);
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (ar_idx == IW'(i)) rd_val = regs[i];
    end
    for (int unsigned j = 0; j < 32'(NUM_RO); j++) begin
      if (ar_idx == IW'(NUM_RW + j)) rd_val = status_in[j*DW +: DW];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ar_pend      <= 1'b0;
      ar_idx       <= '0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= OKAY;
    end else begin
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        ar_pend <= 1'b1;
        ar_idx  <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (ar_pend) begin
        ar_pend      <= 1'b0;
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_val;
        S_AXI_RRESP  <= rd_err ? SLVERR : OKAY;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    ctrl_regs = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) ctrl_regs[i*DW +: DW] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: scoreboard bench for axi_lite_regbank.
//   Expected B/R responses are computed by a register model and queued when a
//   transaction is issued; they are popped and compared when the DUT answers.
module tb_axi_lite_regbank;

  localparam int DW  = 32;
  localparam int AWD = 7;
  localparam int NRW = 14;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AWD-1:0]  awaddr, araddr;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic [NRW*DW-1:0] ctrl_regs;
  logic [2*DW-1:0] status_in;
  logic            busy_in;
  logic            cmd_pulse;
  logic [DW-1:0]   cmd_data;

  always #5 clk = ~clk;

  axi_lite_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AWD),
    .NUM_REGS(16),
    .NUM_RO(2),
    .CMD_IDX(7)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_regs(ctrl_regs), .status_in(status_in), .busy_in(busy_in),
    .cmd_pulse(cmd_pulse), .cmd_data(cmd_data)
  );

  int          total = 0;
  int          bad = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [31:0] m [NRW];
  int          exp_pulses = 0;
  int          pulse_cnt = 0;
  logic [31:0] pulse_data = '0;

  always @(negedge clk) begin
    if (rst_n && cmd_pulse) begin
      pulse_cnt++;
      pulse_data = cmd_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_write(input logic [4:0] idx, input logic [31:0] d,
                                             input logic [3:0] s);
    if (int'(idx) >= NRW) return 2'b10;
    if (idx == 5'd7 && busy_in) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (s[b]) m[idx][b*8 +: 8] = d[b*8 +: 8];
    if (idx == 5'd7) exp_pulses++;
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [4:0] idx);
    if (int'(idx) < NRW) return {2'b00, m[idx]};
    if (idx == 5'd14)    return {2'b00, status_in[31:0]};
    if (idx == 5'd15)    return {2'b00, status_in[63:32]};
    return {2'b10, 32'h0};
  endfunction

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic axi_write(input logic [AWD-1:0] addr, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int hold, output int lat);
    int ws, as, c;
    bit wd, ad, hw, ha;
    logic [1:0] exp;
    bq.push_back(model_write(addr[AWD-1:2], d, s));
    ws = (lead < 0) ? -lead : 0;
    as = (lead > 0) ? lead : 0;
    wd = 0; ad = 0; c = 0;
    awaddr = addr; wdata = d; wstrb = s;
    bready = (hold == 0);
    while (!(wd && ad) && c < 60) begin
      if (c == ws) wvalid = 1'b1;
      if (c == as) awvalid = 1'b1;
      hw = wvalid && wready;
      ha = awvalid && awready;
      @(posedge clk); #1;
      if (hw) begin wvalid = 1'b0; wd = 1; end
      if (ha) begin awvalid = 1'b0; ad = 1; end
      c++;
    end
    if (!(wd && ad)) check("aw_w_timeout", 0, 1);
    lat = 0;
    while (!bvalid && lat < 60) begin @(posedge clk); #1; lat++; end
    exp = bq.pop_front();
    if (!bvalid) begin
      check("b_timeout", 0, 1);
      bready = 1'b1;
      return;
    end
    check("bresp", bresp, exp);
    for (int k = 0; k < hold; k++) begin
      check("b_hold_valid", bvalid, 1);
      check("b_hold_resp", bresp, exp);
      check("b_hold_awready", awready, 0);
      check("b_hold_wready", wready, 0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    check("b_clear", bvalid, 0);
  endtask

  task automatic axi_read(input logic [AWD-1:0] addr, input int hold, output int lat);
    int c;
    bit ha;
    logic [33:0] exp;
    rq.push_back(model_read(addr[AWD-1:2]));
    araddr = addr; arvalid = 1'b1;
    rready = (hold == 0);
    c = 0; ha = 0;
    while (!ha && c < 60) begin
      ha = arready;
      @(posedge clk); #1;
      c++;
    end
    arvalid = 1'b0;
    if (!ha) check("ar_timeout", 0, 1);
    lat = 0;
    while (!rvalid && lat < 60) begin @(posedge clk); #1; lat++; end
    exp = rq.pop_front();
    if (!rvalid) begin
      check("r_timeout", 0, 1);
      rready = 1'b1;
      return;
    end
    check("rdata", rdata, exp[31:0]);
    check("rresp", rresp, exp[33:32]);
    for (int k = 0; k < hold; k++) begin
      check("r_hold_valid", rvalid, 1);
      check("r_hold_data", rdata, exp[31:0]);
      check("r_hold_arready", arready, 0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    check("r_clear", rvalid, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_bvalid", bvalid, 0);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_cmd_pulse", cmd_pulse, 0);
    check("rst_ctrl", |ctrl_regs, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_bresp", bresp, 0);
    for (int i = 0; i < NRW; i++) m[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_awready", awready, 1);
    check("rel_wready", wready, 1);
    check("rel_arready", arready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, p0;
    logic [4:0]  ridx;
    rst_n = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    busy_in = 0;
    status_in = {32'hCAFE0001, 32'hDEADBEEF};
    for (int i = 0; i < NRW; i++) m[i] = '0;
    do_reset();

    // 1: same-cycle AW+W, partial strobe
    axi_write(7'h14, 32'h0000ABCD, 4'b0011, 0, 0, lat);
    check("b_latency", lat, 1);
    axi_read(7'h14, 0, lat);
    check("r_latency", lat, 1);
    check("ctrl_slot5", ctrl_regs[5*DW +: DW], 32'h0000ABCD);

    // 2: W leads AW by 3 cycles, then byte-lane merge
    axi_write(7'h00, 32'h11223344, 4'b1111, 3, 0, lat);
    axi_write(7'h00, 32'hFFFFFFFF, 4'b0100, -2, 0, lat);
    axi_read(7'h00, 0, lat);
    check("merge_0x11FF3344", ctrl_regs[31:0], 32'h11FF3344);

    // 3: RO write error, RO read, out-of-range read/write
    axi_write(7'h38, 32'h12345678, 4'b1111, 0, 0, lat);
    axi_read(7'h38, 0, lat);
    axi_read(7'h3C, 0, lat);
    axi_read(7'h50, 0, lat);
    axi_write(7'h7C, 32'h1, 4'b1111, 1, 0, lat);

    // WSTRB=0 to a valid register: OKAY, no change
    axi_write(7'h14, 32'hFFFFFFFF, 4'b0000, 0, 0, lat);
    axi_read(7'h14, 0, lat);

    // 4: command register, idle then busy
    p0 = pulse_cnt;
    axi_write(7'h1C, 32'h0000005B, 4'b1111, 0, 0, lat);
    repeat (2) @(posedge clk);
    #1;
    check("cmd_pulse_cycles", pulse_cnt - p0, 1);
    check("cmd_data", pulse_data, 32'h5B);
    busy_in = 1;
    p0 = pulse_cnt;
    axi_write(7'h1C, 32'h00000077, 4'b1111, 0, 0, lat);
    repeat (2) @(posedge clk);
    #1;
    check("cmd_busy_no_pulse", pulse_cnt - p0, 0);
    busy_in = 0;
    axi_read(7'h1C, 0, lat);

    // 5: backpressure on B and R
    axi_write(7'h08, 32'hA5A5A5A5, 4'b1111, 0, 5, lat);
    axi_read(7'h08, 4, lat);

    // Random mix of writes/reads with varied channel ordering
    for (int n = 0; n < 24; n++) begin
      ridx = 5'($urandom_range(0, 17));
      busy_in = ($urandom_range(0, 3) == 0);
      axi_write({ridx, 2'b00}, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 4) - 2, $urandom_range(0, 1), lat);
      busy_in = 0;
      axi_read({5'($urandom_range(0, 17)), 2'b00}, $urandom_range(0, 2), lat);
    end
    repeat (2) @(posedge clk);
    #1;
    check("pulse_total", pulse_cnt, exp_pulses);

    // 6: reset after AW accepted, before W
    awaddr = 7'h04; awvalid = 1'b1;
    while (!awready) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    do_reset();
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    while (!wready) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_commit_bvalid", bvalid, 0);
    check("no_commit_regs", |ctrl_regs, 0);
    do_reset();
    axi_read(7'h04, 0, lat);
    axi_read(7'h00, 0, lat);
    axi_read(7'h1C, 0, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
